// File: rtl/mont_domain_convert_if.sv
// mont_domain_convert_if
//   Groups the request and result signals of mont_domain_convert.
//   The master side (the upstream requester or a testbench) drives
//   start/base/N and observes the status flags and results. The slave
//   side is the converter itself.
//
//   Signals:
//     start      request, sampled only while the converter is idle
//     base       ordinary-domain base, must be below N
//     N          odd modulus greater than one
//     busy       converter is doubling or reporting completion
//     finish     one-cycle completion pulse
//     err        one-cycle input-error pulse (CONV_CHECK_EN builds only)
//     one_mont   R mod N, with R = 2^BITS
//     base_mont  base*R mod N
interface mont_domain_convert_if #(
  parameter int BITS = 578
);
  logic            start;
  logic [BITS-1:0] base;
  logic [BITS-1:0] N;
  logic            busy;
  logic            finish;
  logic            err;
  logic [BITS-1:0] one_mont;
  logic [BITS-1:0] base_mont;

  modport master (
    output start, base, N,
    input  busy, finish, err, one_mont, base_mont
  );

  modport slave (
    input  start, base, N,
    output busy, finish, err, one_mont, base_mont
  );
endinterface

// File: rtl/mont_domain_convert.sv
// mont_domain_convert
//   Converts an ordinary-domain base and the constant one into the
//   Montgomery domain for modulus N, with R = 2^BITS:
//     one_mont  = R mod N
//     base_mont = base*R mod N
//   Both accumulators start at 1 and base and are doubled modulo N once
//   per cycle, BITS times, so no multiplier is needed; each doubling is a
//   single compare-and-subtract per operand.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   mont_domain_convert_if slave modport (start, base, N in;
//           busy, finish, err, one_mont, base_mont out)
//
//   Parameters:
//     BITS   operand width, R = 2^BITS
//     CNT_W  doubling counter width, 2^CNT_W must exceed BITS
//
//   Optional feature, macro CONV_CHECK_EN:
//     When defined, a start request with an even N, N <= 1 or base >= N
//     is refused: err pulses for one cycle, the converter stays idle and
//     the previous results are kept. When undefined, err is tied low and
//     every request is accepted.
module mont_domain_convert #(
  parameter int BITS  = 578,
  parameter int CNT_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  mont_domain_convert_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DOUBLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [BITS-1:0]  r_n;
  logic [BITS-1:0]  r_acc_one;
  logic [BITS-1:0]  r_acc_base;
  logic [CNT_W-1:0] r_count;
  logic             w_in_bad;
  logic             w_accept;

  // Modular doubling of a value already in [0, m). The shifted value is
  // kept one bit wider than the operand so a modulus close to 2^BITS
  // cannot lose the carry out of the shift.
  function automatic logic [BITS-1:0] modDouble(
    input logic [BITS-1:0] a,
    input logic [BITS-1:0] m
  );
    logic [BITS:0] t;
    t = {a, 1'b0};
    if (t >= {1'b0, m}) begin
      t = t - {1'b0, m};
    end
    return t[BITS-1:0];
  endfunction

`ifdef CONV_CHECK_EN
  logic r_err;

  // A request is unusable when the modulus is even or trivial, or when
  // the base is not already reduced modulo N.
  assign w_in_bad = (bus.N[0] == 1'b0) ||
                    (bus.N <= BITS'(1)) ||
                    (bus.base >= bus.N);

  // The error flag is a one-cycle pulse following a refused request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == IDLE) && bus.start && w_in_bad;
    end
  end

  assign bus.err = r_err;
`else
  assign w_in_bad = 1'b0;
  assign bus.err  = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && bus.start && !w_in_bad;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. Requests arriving outside IDLE are simply not
  // looked at, so an in-flight conversion is never disturbed.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = DOUBLE;
        end
      end
      DOUBLE: begin
        if (r_count == '0) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    bus.busy   = 1'b0;
    bus.finish = 1'b0;
    case (r_state)
      DOUBLE: begin
        bus.busy = 1'b1;
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.finish = 1'b1;
      end
      default: begin
        bus.busy   = 1'b0;
        bus.finish = 1'b0;
      end
    endcase
  end

  // Datapath. The counter is loaded with BITS-1 and the last doubling
  // happens in the cycle it reads zero, giving exactly BITS doublings.
  // The accumulators double as the result registers, so results stay
  // visible in IDLE until the next accepted request overwrites them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n        <= '0;
      r_acc_one  <= '0;
      r_acc_base <= '0;
      r_count    <= CNT_W'(BITS - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_n        <= bus.N;
            r_acc_one  <= BITS'(1);
            r_acc_base <= bus.base;
            r_count    <= CNT_W'(BITS - 1);
          end
        end
        DOUBLE: begin
          r_acc_one  <= modDouble(r_acc_one, r_n);
          r_acc_base <= modDouble(r_acc_base, r_n);
          if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.one_mont  = r_acc_one;
  assign bus.base_mont = r_acc_base;

endmodule
